fsqrt_issue_ctrl: RTL and testbench
===================================

// Module: fsqrt_issue_ctrl
// PURPOSE
// Handshaked front end for the fixed-latency, non-stallable fsqrt core.
// Accepts operands with valid/ready and resolves IEEE special cases locally.
// Tracks in-flight ops in a LATENCY-deep shadow pipe and lands results in a
// credit-guarded output FIFO, so downstream backpressure never drops a result.
// Sits between FPU dispatch and the fsqrt core; results return in issue order.
// PARAMETERS
// LATENCY     2   clock edges from core_x presented to matching core_y valid
// FIFO_DEPTH  4   output FIFO entries (power of 2, >= 2); also max ops outstanding
// TAG_W       4   width of the opaque tag carried alongside each op
// PORTS
// clk        in   1      clock, all state on rising edge
// rstn       in   1      asynchronous active-low reset
// in_valid   in   1      operand valid
// in_ready   out  1      block can accept the operand this cycle
// in_x       in   32     IEEE-754 single operand
// in_tag     in   TAG_W  tag returned with the result
// core_x     out  32     operand to fsqrt core
// core_y     in   32     fsqrt core result, LATENCY edges after core_x
// out_valid  out  1      FIFO head valid
// out_ready  in   1      consumer accepts the head
// out_y      out  32     result
// out_tag    out  TAG_W  tag of the result
// out_inv    out  1      invalid-operation flag for this result
// BEHAVIOUR
// - fire = in_valid & in_ready. Reset: in_ready=1, out_valid=0, out_y=0, out_tag=0,
//   out_inv=0, core_x=0. The shadow pipe and FIFO are emptied.
// - core_x = fire ? in_x : 32'd0. Combinational, so idle cycles feed the core zero.
// - Credits: in_ready = (pipe_cnt + fifo_cnt) < FIFO_DEPTH. pipe_cnt is the number of
//   valid shadow stages. A pop in the same cycle is NOT credited; there is no
//   comb path out_ready->in_ready.
// - Special classification at issue. Exp==0 (zero or denormal, flushed) -> {sign,31'b0}.
//   +inf -> 0x7F800000. NaN -> 0x7FC00000, with inv=1 iff bit22==0 (sNaN).
//   Sign=1 and nonzero (incl -inf, not denormal) -> 0x7FC00000, inv=1.
//   All other operands are normal: use core_y, inv=0.
// - Shadow pipe: LATENCY stages of {v, tag, spec, spec_val, inv}. Stage 0 loads on fire;
//   it shifts every cycle unconditionally, and the core cannot stall.
// - At pipe exit with v=1: push {spec ? spec_val : core_y, tag, inv} into the FIFO.
//   Specials ride the pipe, so ordering is strict FIFO.
// - FIFO: push and pop in the same cycle is legal at any count, including full;
//   the count is unchanged. Pointers wrap modulo FIFO_DEPTH. Credits guarantee no
//   push when full. Overflow is a design error; assert it in simulation.
// - out_* show the FIFO head (registered storage). out_valid = fifo_cnt != 0.
//   Pop when out_valid & out_ready.
// - in_x and in_tag are sampled only on fire. in_valid while in_ready=0 has no effect.
// - Async rstn mid-operation: in-flight and queued ops are discarded. The core is
//   not reset; its stale core_y is ignored because shadow v=0.
// - Throughput: 1 op/cycle while out_ready=1. Min in->out latency is LATENCY+1
//   edges, since the FIFO is registered.
// TESTING
// 1 Reset: assert rstn=0 with 3 ops queued -> out_valid=0 and in_ready=1
//   immediately; no stale output after release.
// 2 Streaming, out_ready=1: in_x=0x40800000 tag1, 0x40000000 tag2, 0x40400000 tag3
//   back-to-back -> 0x40000000, 0x3FB504F3, 0x3FDDB3D7 (+/- core ulp) at
//   LATENCY+1 cycles, tags 1,2,3 in order.
// 3 Specials: 0x00000000->0x00000000; 0x80000000->0x80000000; 0x00000001->0x00000000;
//   0x7F800000->0x7F800000 inv=0; 0xC0000000->0x7FC00000 inv=1;
//   0x7F800001->0x7FC00000 inv=1; 0x7FC00000->0x7FC00000 inv=0.
// 4 Backpressure: out_ready=0, in_valid=1 held -> exactly FIFO_DEPTH fires, then
//   in_ready=0. Raise out_ready -> all drain in order; in_ready returns 1 cycle after
//   the first pop.
// 5 Full FIFO with in-flight pop+push in one cycle -> fifo_cnt constant, no loss,
//   order kept, overflow assertion silent.
// 6 Mixed special/normal interleave: 0x40800000, 0xBF800000, 0x437F0000 -> results
//   in issue order; inv only on the second.

Source files
------------

// File: rtl/fsqrt_issue_ctrl.sv
// Valid/ready front end for a fixed-latency, non-stallable fsqrt core.
// Resolves IEEE specials at issue and lands results in a credit-guarded output FIFO.
module fsqrt_issue_ctrl #(
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      core_x,
    input  logic [31:0]      core_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_inv
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int CRED_W = $clog2(FIFO_DEPTH + LATENCY + 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    logic             fire;
    logic [7:0]       x_exp;
    logic [22:0]      x_man;
    logic             x_spec;
    logic [31:0]      x_spec_val;
    logic             x_inv;

    logic             pipe_v_q    [LATENCY];
    logic             pipe_v_d    [LATENCY];
    logic [TAG_W-1:0] pipe_tag_q  [LATENCY];
    logic [TAG_W-1:0] pipe_tag_d  [LATENCY];
    logic             pipe_spec_q [LATENCY];
    logic             pipe_spec_d [LATENCY];
    logic [31:0]      pipe_sval_q [LATENCY];
    logic [31:0]      pipe_sval_d [LATENCY];
    logic             pipe_inv_q  [LATENCY];
    logic             pipe_inv_d  [LATENCY];
    logic [CRED_W-1:0] pipe_cnt;

    logic [31:0]      mem_y_q   [FIFO_DEPTH];
    logic [31:0]      mem_y_d   [FIFO_DEPTH];
    logic [TAG_W-1:0] mem_tag_q [FIFO_DEPTH];
    logic [TAG_W-1:0] mem_tag_d [FIFO_DEPTH];
    logic             mem_inv_q [FIFO_DEPTH];
    logic             mem_inv_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic             fifo_push;
    logic             fifo_pop;
    logic [31:0]      push_y;

    assign fire   = in_valid & in_ready;
    assign core_x = fire ? in_x : 32'd0;
    assign x_exp  = in_x[30:23];
    assign x_man  = in_x[22:0];

    // Credits count every op not yet popped; a same-cycle pop is deliberately ignored.
    assign in_ready = (pipe_cnt + CRED_W'(fifo_cnt_q)) < CRED_W'(FIFO_DEPTH);

    always_comb begin
        pipe_cnt = '0;
        for (int i = 0; i < LATENCY; i++) begin
            pipe_cnt = pipe_cnt + CRED_W'(pipe_v_q[i]);
        end
    end

    always_comb begin
        x_spec     = 1'b1;
        x_spec_val = 32'd0;
        x_inv      = 1'b0;
        if (x_exp == 8'd0) begin
            x_spec_val = {in_x[31], 31'd0};
        end else if (x_exp == 8'hFF && x_man != 23'd0) begin
            x_spec_val = QNAN;
            x_inv      = ~x_man[22];
        end else if (in_x[31]) begin
            x_spec_val = QNAN;
            x_inv      = 1'b1;
        end else if (x_exp == 8'hFF) begin
            x_spec_val = PINF;
        end else begin
            x_spec = 1'b0;
        end
    end

    // The shadow pipe shifts every cycle because the core itself can never stall.
    always_comb begin
        pipe_v_d[0]    = fire;
        pipe_tag_d[0]  = fire ? in_tag     : pipe_tag_q[0];
        pipe_spec_d[0] = fire ? x_spec     : pipe_spec_q[0];
        pipe_sval_d[0] = fire ? x_spec_val : pipe_sval_q[0];
        pipe_inv_d[0]  = fire ? x_inv      : pipe_inv_q[0];
        for (int i = 1; i < LATENCY; i++) begin
            pipe_v_d[i]    = pipe_v_q[i-1];
            pipe_tag_d[i]  = pipe_tag_q[i-1];
            pipe_spec_d[i] = pipe_spec_q[i-1];
            pipe_sval_d[i] = pipe_sval_q[i-1];
            pipe_inv_d[i]  = pipe_inv_q[i-1];
        end
    end

    assign fifo_push = pipe_v_q[LATENCY-1];
    assign fifo_pop  = out_valid & out_ready;
    assign push_y    = pipe_spec_q[LATENCY-1] ? pipe_sval_q[LATENCY-1] : core_y;

    always_comb begin
        mem_y_d    = mem_y_q;
        mem_tag_d  = mem_tag_q;
        mem_inv_d  = mem_inv_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (fifo_push) begin
            mem_y_d[wr_ptr_q]   = push_y;
            mem_tag_d[wr_ptr_q] = pipe_tag_q[LATENCY-1];
            mem_inv_d[wr_ptr_q] = pipe_inv_q[LATENCY-1];
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    assign out_valid = fifo_cnt_q != '0;
    assign out_y     = mem_y_q[rd_ptr_q];
    assign out_tag   = mem_tag_q[rd_ptr_q];
    assign out_inv   = mem_inv_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_v_q[i]    <= 1'b0;
                pipe_tag_q[i]  <= '0;
                pipe_spec_q[i] <= 1'b0;
                pipe_sval_q[i] <= 32'd0;
                pipe_inv_q[i]  <= 1'b0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_y_q[i]   <= 32'd0;
                mem_tag_q[i] <= '0;
                mem_inv_q[i] <= 1'b0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            pipe_v_q    <= pipe_v_d;
            pipe_tag_q  <= pipe_tag_d;
            pipe_spec_q <= pipe_spec_d;
            pipe_sval_q <= pipe_sval_d;
            pipe_inv_q  <= pipe_inv_d;
            mem_y_q     <= mem_y_d;
            mem_tag_q   <= mem_tag_d;
            mem_inv_q   <= mem_inv_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // A push into a full FIFO without a pop means the credit scheme is broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(fifo_push && !fifo_pop && fifo_cnt_q == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fsqrt_issue_ctrl.sv
// Self-checking bench for fsqrt_issue_ctrl: ideal fsqrt core model plus an
// in-order scoreboard of expected results derived from the IEEE special rules.
module tb_fsqrt_issue_ctrl;

    localparam int LATENCY    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int TAG_W      = 4;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_x = 32'd0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [31:0]      core_x;
    logic [31:0]      core_y;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_y;
    logic [TAG_W-1:0] out_tag;
    logic             out_inv;

    fsqrt_issue_ctrl #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_tag(in_tag), .core_x(core_x), .core_y(core_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_tag(out_tag), .out_inv(out_inv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
        logic             inv;
        int               issue;
    } exp_t;

    exp_t             sb[$];
    int               total = 0;
    int               bad = 0;
    int               cyc = 0;
    logic             s_fire, s_pop, s_ready, s_ovalid, s_inv, s_head_ok, e_ready, e_ovalid;
    logic [31:0]      s_y, s_core_x;
    logic [TAG_W-1:0] s_tag;
    exp_t             s_head;

    // Correctly rounded single-precision sqrt of a positive normal operand.
    function automatic logic [31:0] sqrt_ref(input logic [31:0] x);
        logic [63:0] d;
        logic [30:0] res;
        logic        inc;
        real         r;
        d   = {1'b0, 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
        r   = $sqrt($bitstoreal(d));
        d   = $realtobits(r);
        inc = d[28] & ((d[27:0] != 28'd0) | d[29]);
        res = {8'(int'(d[62:52]) - 1023 + 127), d[51:29]} + 31'(inc);
        return {1'b0, res};
    endfunction

    function automatic logic [31:0] core_fn(input logic [31:0] x);
        if (!x[31] && x[30:23] != 8'd0 && x[30:23] != 8'hFF) return sqrt_ref(x);
        return 32'hDEAD_BEEF;
    endfunction

    function automatic void ref_result(input logic [31:0] x, output logic [31:0] y, output logic inv);
        bit is_flushed = (x[30:23] == 8'd0);
        bit is_nan     = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        bit is_pinf    = (x == 32'h7F80_0000);
        inv = 1'b0;
        if (is_flushed)     y = {x[31], 31'd0};
        else if (is_nan)    begin y = 32'h7FC0_0000; inv = !x[22]; end
        else if (x[31])     begin y = 32'h7FC0_0000; inv = 1'b1; end
        else if (is_pinf)   y = 32'h7F80_0000;
        else                y = sqrt_ref(x);
    endfunction

    function automatic logic [31:0] rand_normal();
        return {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return {1'($urandom), 8'd0, 23'($urandom_range(0, 3))};
            1:       return {1'($urandom), 31'h7F80_0000};
            2:       return {1'($urandom), 8'hFF, 1'($urandom), 22'($urandom_range(1, 100))};
            3:       return {1'b1, 8'($urandom_range(1, 254)), 23'($urandom)};
            default: return rand_normal();
        endcase
    endfunction

    // Ideal non-stallable core: result appears LATENCY edges after core_x.
    logic [31:0] core_pipe [LATENCY];
    always @(posedge clk) begin
        core_pipe[0] <= core_fn(core_x);
        for (int i = 1; i < LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_y = core_pipe[LATENCY-1];

    // One cycle: drive at negedge, sample #1 later, update the scoreboard.
    task automatic step(input logic v, input logic [31:0] x, input logic [TAG_W-1:0] tg, input logic ordy);
        logic [31:0] ey;
        logic        einv;
        exp_t        e;
        @(negedge clk);
        in_valid = v; in_x = x; in_tag = tg; out_ready = ordy;
        #1;
        e_ready  = (sb.size() < FIFO_DEPTH);
        e_ovalid = 1'b0;
        if (sb.size() != 0) e_ovalid = (cyc - sb[0].issue) >= LATENCY + 1;
        s_ready = in_ready; s_ovalid = out_valid; s_y = out_y; s_tag = out_tag;
        s_inv = out_inv; s_core_x = core_x;
        s_fire = v && in_ready;
        s_pop  = out_valid && ordy;
        s_head_ok = 1'b0;
        if (s_pop && sb.size() != 0) begin
            s_head = sb.pop_front();
            s_head_ok = 1'b1;
        end
        if (s_fire) begin
            ref_result(x, ey, einv);
            e.y = ey; e.tag = tg; e.inv = einv; e.issue = cyc;
            sb.push_back(e);
        end
        cyc++;
    endtask

    task automatic test_reset();
        int stale = 0;
        #3;
        total++;
        if ({in_ready, out_valid, out_y, out_tag, out_inv, core_x} !== {2'b10, 32'd0, {TAG_W{1'b0}}, 1'b0, 32'd0}) begin
            bad++;
            $display("[TB] FAIL reset_values got rdy=%b ov=%b y=%h tag=%h inv=%b cx=%h want rdy=1 ov=0 rest 0",
                     in_ready, out_valid, out_y, out_tag, out_inv, core_x);
        end
        @(negedge clk); rstn = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, rand_normal(), TAG_W'(i), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, '0, 1'b0);
        total++;
        if (s_ovalid !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_prefill out_valid got %b want 1", s_ovalid);
        end
        @(negedge clk); #2 rstn = 1'b0; #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_async_ovalid got %b want 0", out_valid);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_async_ready got %b want 1", in_ready);
        end
        sb.delete();
        @(negedge clk); rstn = 1'b1; #1;
        total++;
        if (out_y !== 32'd0) begin
            bad++; $display("[TB] FAIL reset_out_y got %h want 00000000", out_y);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'd0, '0, 1'b1);
            if (s_ovalid) stale++;
        end
        total++;
        if (stale != 0) begin
            bad++; $display("[TB] FAIL reset_stale got %0d stale valid cycles want 0", stale);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] xs [3] = '{32'h4080_0000, 32'h4000_0000, 32'h4040_0000};
        logic [31:0] ws [3] = '{32'h4000_0000, 32'h3FB5_04F3, 32'h3FDD_B3D7};
        int k = 0;
        int diff;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, xs[i], TAG_W'(i + 1), 1'b1);
            total++;
            if (!s_fire || s_core_x !== xs[i]) begin
                bad++; $display("[TB] FAIL stream_issue%0d got fire=%b core_x=%h want fire=1 core_x=%h", i, s_fire, s_core_x, xs[i]);
            end
        end
        for (int i = 0; i < 12 && k < 3; i++) begin
            step(1'b0, 32'hFFFF_FFFF, '0, 1'b1);
            total++;
            if (s_core_x !== 32'd0) begin
                bad++; $display("[TB] FAIL stream_idle_core_x got %h want 00000000", s_core_x);
            end
            if (s_pop) begin
                diff = int'(s_y) - int'(ws[k]);
                total++;
                if (!s_head_ok || diff > 1 || diff < -1 || s_tag !== TAG_W'(k + 1) || s_inv !== 1'b0) begin
                    bad++; $display("[TB] FAIL stream_result%0d got y=%h tag=%0d inv=%b want y=%h tag=%0d inv=0", k, s_y, s_tag, s_inv, ws[k], k + 1);
                end
                total++;
                if ((cyc - 1) - s_head.issue != LATENCY + 1) begin
                    bad++; $display("[TB] FAIL stream_latency%0d got %0d want %0d", k, (cyc - 1) - s_head.issue, LATENCY + 1);
                end
                k++;
            end
        end
        total++;
        if (k != 3) begin
            bad++; $display("[TB] FAIL stream_count got %0d results want 3", k);
        end
    endtask

    task automatic test_specials();
        logic [31:0] xs [7] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 32'h7F80_0000,
                                32'hC000_0000, 32'h7F80_0001, 32'h7FC0_0000};
        logic [31:0] ws [7] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h7F80_0000,
                                32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000};
        logic        wi [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int k = 0;
        for (int i = 0; i < 20 && k < 7; i++) begin
            if (i < 7) step(1'b1, xs[i], TAG_W'(i), 1'b1);
            else       step(1'b0, 32'd0, '0, 1'b1);
            if (s_pop) begin
                total++;
                if (s_y !== ws[k] || s_inv !== wi[k] || s_tag !== TAG_W'(k)) begin
                    bad++; $display("[TB] FAIL special%0d got y=%h inv=%b tag=%0d want y=%h inv=%b tag=%0d", k, s_y, s_inv, s_tag, ws[k], wi[k], k);
                end
                k++;
            end
        end
        total++;
        if (k != 7) begin
            bad++; $display("[TB] FAIL special_count got %0d want 7", k);
        end
    endtask

    task automatic test_backpressure();
        int fires = 0;
        int pops = 0;
        logic rdy_first = 1'b1;
        logic rdy_next = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, rand_normal(), TAG_W'($urandom), 1'b0);
            if (s_fire) fires++;
        end
        total++;
        if (fires != FIFO_DEPTH || s_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL bp_fill got fires=%0d ready=%b want fires=%0d ready=0", fires, s_ready, FIFO_DEPTH);
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            step(1'b0, 32'd0, '0, 1'b1);
            if (pops == 1 && i > 0) rdy_next = s_ready;
            if (s_pop) begin
                if (pops == 0) rdy_first = s_ready;
                pops++;
                total++;
                if (!s_head_ok || s_y !== s_head.y || s_tag !== s_head.tag || s_inv !== s_head.inv) begin
                    bad++; $display("[TB] FAIL bp_drain got y=%h tag=%0d inv=%b want y=%h tag=%0d inv=%b", s_y, s_tag, s_inv, s_head.y, s_head.tag, s_head.inv);
                end
            end
        end
        total++;
        if (pops != FIFO_DEPTH || sb.size() != 0) begin
            bad++; $display("[TB] FAIL bp_drain_count got %0d want %0d", pops, FIFO_DEPTH);
        end
        total++;
        if (rdy_first !== 1'b0 || rdy_next !== 1'b1) begin
            bad++; $display("[TB] FAIL bp_ready_return got first=%b next=%b want first=0 next=1", rdy_first, rdy_next);
        end
    endtask

    // Shared per-cycle body for the long runs: credits, head visibility and data.
    task automatic run_checked(input int n, input int vpct, input int rpct, input bit specials, input string nm);
        logic [31:0] x;
        for (int i = 0; i < n; i++) begin
            x = specials ? rand_operand() : rand_normal();
            step(1'($urandom_range(0, 99) < vpct), x, TAG_W'($urandom), 1'($urandom_range(0, 99) < rpct));
            total++;
            if (s_ready !== e_ready || s_ovalid !== e_ovalid) begin
                bad++; $display("[TB] FAIL %s_flow cyc=%0d got ready=%b ovalid=%b want ready=%b ovalid=%b", nm, cyc, s_ready, s_ovalid, e_ready, e_ovalid);
            end
            if (s_pop) begin
                total++;
                if (!s_head_ok || s_y !== s_head.y || s_tag !== s_head.tag || s_inv !== s_head.inv) begin
                    bad++; $display("[TB] FAIL %s_data got y=%h tag=%0d inv=%b want y=%h tag=%0d inv=%b", nm, s_y, s_tag, s_inv, s_head.y, s_head.tag, s_head.inv);
                end
            end
        end
    endtask

    task automatic test_full_pushpop();
        run_checked(8, 100, 0, 1'b0, "full_fill");
        run_checked(30, 100, 100, 1'b0, "full_stream");
        run_checked(15, 0, 100, 1'b0, "full_drain");
        total++;
        if (sb.size() != 0) begin
            bad++; $display("[TB] FAIL full_leftover got %0d want 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        run_checked(300, 75, 65, 1'b1, "random");
        run_checked(20, 0, 100, 1'b1, "random_drain");
        total++;
        if (sb.size() != 0) begin
            bad++; $display("[TB] FAIL random_leftover got %0d want 0", sb.size());
        end
    endtask

    task automatic test_mixed();
        logic [31:0] xs [3] = '{32'h4080_0000, 32'hBF80_0000, 32'h437F_0000};
        logic [31:0] want0 = 32'h4000_0000;
        logic [31:0] want1 = 32'h7FC0_0000;
        int k = 0;
        for (int i = 0; i < 15 && k < 3; i++) begin
            if (i < 3) step(1'b1, xs[i], TAG_W'(i + 5), 1'b1);
            else       step(1'b0, 32'd0, '0, 1'b1);
            if (s_pop) begin
                total++;
                if (!s_head_ok || s_y !== s_head.y || s_tag !== TAG_W'(k + 5) || s_inv !== (k == 1)) begin
                    bad++; $display("[TB] FAIL mixed%0d got y=%h tag=%0d inv=%b want y=%h tag=%0d inv=%b", k, s_y, s_tag, s_inv, s_head.y, k + 5, k == 1);
                end
                if (k == 0 || k == 1) begin
                    total++;
                    if (s_y !== ((k == 0) ? want0 : want1)) begin
                        bad++; $display("[TB] FAIL mixed_const%0d got %h want %h", k, s_y, (k == 0) ? want0 : want1);
                    end
                end
                k++;
            end
        end
        total++;
        if (k != 3) begin
            bad++; $display("[TB] FAIL mixed_count got %0d want 3", k);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_specials();
        test_backpressure();
        test_full_pushpop();
        test_mixed();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
